mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage sitting directly downstream of the execute stage. It takes the load and store requests computed in execute and runs them as single word-bus transactions with a req/ack handshake. It performs byte-lane alignment, store strobes, load sign- or zero-extension and misalignment detection. Loaded data goes to the register file as a one-cycle write pulse, and the upstream pipeline is stalled while a transaction is outstanding.

## Interface
- `TIMEOUT_CYCLES`, default 255: number of cycles to wait for `bus_ack` after `bus_req` rises before aborting; 0 disables the timeout. Counter width is 8 bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `mem_load_mode`  in  3  encoding: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 111 means no load; 011 and 110 are ignored.
- `mem_load_addr`  in  32  byte address of the load.
- `mem_load_regs_addr`  in  5  load destination register.
- `mem_store_mode`  in  2  encoding: 00 none, 01 SB, 10 SH, 11 SW.
- `mem_store_addr`  in  32  byte address of the store.
- `mem_store_data`  in  32  store data, right-aligned.
- `bus_req`  out  1  transaction request; held high until ack or timeout.
- `bus_we`  out  1  1 = store, 0 = load.
- `bus_addr`  out  32  word address, always `{addr[31:2], 2'b00}`.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_wstrb`  out  4  byte enables; 0000 for loads.
- `bus_ack`  in  1  transaction complete; sampled only while `bus_req` is high.
- `bus_rdata`  in  32  read word; valid in the `bus_ack` cycle.
- `regs_write_en`  out  1  register write pulse.
- `regs_write_addr`  out  5  register write address.
- `regs_write_data`  out  32  register write data.
- `pause_signal`  out  1  combinational stall request to the upstream pipeline.
- `misalign_error`  out  1  one-cycle pulse: access rejected because it is misaligned.
- `bus_timeout`  out  1  one-cycle pulse: transaction aborted by the timeout.

## Operation
- **States:** IDLE, LOAD_WAIT, STORE_WAIT.
- **Request detection in IDLE:**
  - A load request is any valid load mode.
  - A store request is `mem_store_mode != 00`.
  - If both are present, the load is taken and the store is dropped.
- **Alignment rules:**
  - Halfword accesses (LH, LHU, SH) require `addr[0] == 0`.
  - Word accesses (LW, SW) require `addr[1:0] == 00`.
  - A misaligned request is not accepted: no bus activity, `misalign_error` pulses in the next cycle, and the FSM stays in IDLE.
- **Accept:** an aligned request in IDLE is latched at the clock edge. The FSM moves to LOAD_WAIT or STORE_WAIT, and `bus_req` plus all bus fields are registered at that same edge.
- **Store lane mapping:**
  - SB: `bus_wdata = {4{data[7:0]}}`, `bus_wstrb = 0001 << addr[1:0]`.
  - SH: `bus_wdata = {2{data[15:0]}}`, `bus_wstrb = addr[1] ? 1100 : 0011`.
  - SW: `bus_wdata = data`, `bus_wstrb = 1111`.
- **Load extraction:**
  - Byte loads select the lane `rdata >> (8*addr[1:0])`.
  - Halfword loads select `addr[1] ? rdata[31:16] : rdata[15:0]`.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- **Completion:**
  - On `bus_ack` in a WAIT state, `bus_req`, `bus_we`, `bus_wstrb` and `bus_wdata` clear and the FSM returns to IDLE.
  - For a load, the `regs_write_*` registers are loaded at the same edge.
  - `regs_write_en` is 1 only if the latched rd != 0. A load to x0 still performs the bus read.
- **Timeout:**
  - The wait counter clears on accept and increments each WAIT cycle without ack.
  - When it reaches `TIMEOUT_CYCLES` (nonzero), the block drops `bus_req`, returns to IDLE, pulses `bus_timeout` and does no writeback.
- **pause_signal** = `rst_n & ((IDLE & aligned request present) | (WAIT & !bus_ack & !timeout_hit))`.
  - It is low in the ack cycle, so upstream advances at the same edge the FSM returns to IDLE.
  - This prevents a held request from being re-accepted.
- **bus_ack outside WAIT** (including after a reset that interrupted a transaction) is ignored.

## Timing
- **Reset:** `rst_n` low at an edge sends the FSM to IDLE and zeroes the counter and every registered output: `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_wstrb`, `regs_write_en`, `regs_write_addr`, `regs_write_data`, `misalign_error`, `bus_timeout`. `pause_signal` is 0 while `rst_n` is low. Reset mid-transaction abandons it with no writeback.
- **Load latency:**
  - Cycle 0: request present, `pause_signal` = 1.
  - Cycle 1: `bus_req` = 1. If `bus_ack` = 1 here, `pause_signal` = 0.
  - Cycle 2: `regs_write_en` = 1 for exactly one cycle.
  - Each wait cycle without ack adds one cycle.
- **Store latency:** same as load, but with no writeback.
- **Back-to-back:** the cycle after an ack the FSM is in IDLE and may accept the next request, giving one transaction per 2 cycles at zero wait.
- **Pulse outputs:** `misalign_error` and `bus_timeout` are high in the cycle after detection and never for more than one consecutive cycle per event.

## Test plan
- **LB with sign extension:** LB (000) at 0x0000_1003, rd=5; ack in cycle 1 with rdata 0x80AA_BBCC → cycle 2: `regs_write_en`=1, addr 5, data 0xFFFF_FF80. `bus_addr` = 0x0000_1000, `bus_wstrb` = 0000.
- **SH upper lane:** SH (10) at 0x0000_2002, data 0x1234_ABCD → `bus_we`=1, `bus_addr` 0x0000_2000, `bus_wdata` 0xABCD_ABCD, `bus_wstrb` 1100. `pause_signal` is high until the ack cycle, and there is no register write.
- **Misaligned LW:** LW at 0x0000_0006 → no `bus_req`, `misalign_error` pulses 1 cycle, `pause_signal` stays 0.
- **Timeout:** with `TIMEOUT_CYCLES`=4, LHU at 0x10 with no ack → `bus_req` high for 4 cycles, then drops; `bus_timeout` pulses; no writeback; the FSM accepts a new request afterwards.
- **x0 destination and late ack:** LW to rd=0 with ack after 3 wait cycles → bus read occurs, `regs_write_en` stays 0, `pause_signal` is high through the 3 wait cycles.
- **Reset mid-transaction:** `rst_n` low in LOAD_WAIT, then ack arrives after reset → all outputs 0, no writeback, FSM in IDLE.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access stage: runs execute-stage loads/stores as single word-bus req/ack
// transactions with lane steering, load extension, misalignment rejection and timeout.
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  mem_load_mode,
  input  logic [31:0] mem_load_addr,
  input  logic [4:0]  mem_load_regs_addr,
  input  logic [1:0]  mem_store_mode,
  input  logic [31:0] mem_store_addr,
  input  logic [31:0] mem_store_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        regs_write_en,
  output logic [4:0]  regs_write_addr,
  output logic [31:0] regs_write_data,
  output logic        pause_signal,
  output logic        misalign_error,
  output logic        bus_timeout
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned RAW   = 5;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_WAIT  = 2'd1,
    STORE_WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        ld_mode_q, ld_mode_d;
  logic [1:0]        ld_off_q, ld_off_d;
  logic [RAW-1:0]    rd_q, rd_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [XLEN-1:0]   bus_addr_q, bus_addr_d;
  logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
  logic [3:0]        bus_wstrb_q, bus_wstrb_d;
  logic              wr_en_q, wr_en_d;
  logic [RAW-1:0]    wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]   wr_data_q, wr_data_d;
  logic              mis_q, mis_d;
  logic              tmo_q, tmo_d;

  logic              load_valid, load_aligned, store_valid, store_aligned;
  logic              req_present, req_aligned, in_wait, timeout_hit;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [XLEN-1:0]   load_data;

  // Request decode; a valid load takes priority over a simultaneous store
  always_comb begin
    load_valid    = 1'b0;
    load_aligned  = 1'b1;
    store_aligned = 1'b1;
    case (mem_load_mode)
      3'b000, 3'b100: load_valid = 1'b1;
      3'b001, 3'b101: begin
        load_valid   = 1'b1;
        load_aligned = ~mem_load_addr[0];
      end
      3'b010: begin
        load_valid   = 1'b1;
        load_aligned = (mem_load_addr[1:0] == 2'b00);
      end
      default: load_valid = 1'b0;
    endcase
    store_valid = (mem_store_mode != 2'b00);
    case (mem_store_mode)
      2'b10:   store_aligned = ~mem_store_addr[0];
      2'b11:   store_aligned = (mem_store_addr[1:0] == 2'b00);
      default: store_aligned = 1'b1;
    endcase
    req_present = load_valid | store_valid;
    req_aligned = load_valid ? load_aligned : store_aligned;
  end

  assign in_wait     = (state_q != IDLE);
  assign timeout_hit = in_wait & ~bus_ack & (TIMEOUT_CYCLES != 0) &
                       ((32'(cnt_q) + 32'd1) == TIMEOUT_CYCLES);

  // Lane extraction and extension of the returned word
  always_comb begin
    rd_byte = 8'(bus_rdata >> {ld_off_q, 3'b000});
    rd_half = ld_off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (ld_mode_q)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_data = {24'd0, rd_byte};
      3'b101:  load_data = {16'd0, rd_half};
      default: load_data = bus_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ld_mode_d    = ld_mode_q;
    ld_off_d     = ld_off_q;
    rd_d         = rd_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_wstrb_d  = bus_wstrb_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    mis_d        = 1'b0;
    tmo_d        = 1'b0;
    pause_signal = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_present && !req_aligned) begin
          mis_d = 1'b1;
        end else if (req_present) begin
          pause_signal = 1'b1;
          cnt_d        = '0;
          bus_req_d    = 1'b1;
          if (load_valid) begin
            state_d     = LOAD_WAIT;
            bus_we_d    = 1'b0;
            bus_addr_d  = {mem_load_addr[31:2], 2'b00};
            bus_wdata_d = '0;
            bus_wstrb_d = 4'b0000;
            ld_mode_d   = mem_load_mode;
            ld_off_d    = mem_load_addr[1:0];
            rd_d        = mem_load_regs_addr;
          end else begin
            state_d    = STORE_WAIT;
            bus_we_d   = 1'b1;
            bus_addr_d = {mem_store_addr[31:2], 2'b00};
            case (mem_store_mode)
              2'b01: begin
                bus_wdata_d = {4{mem_store_data[7:0]}};
                bus_wstrb_d = 4'b0001 << mem_store_addr[1:0];
              end
              2'b10: begin
                bus_wdata_d = {2{mem_store_data[15:0]}};
                bus_wstrb_d = mem_store_addr[1] ? 4'b1100 : 4'b0011;
              end
              default: begin
                bus_wdata_d = mem_store_data;
                bus_wstrb_d = 4'b1111;
              end
            endcase
          end
        end
      end
      LOAD_WAIT, STORE_WAIT: begin
        if (bus_ack || timeout_hit) begin
          state_d     = IDLE;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_wdata_d = '0;
          bus_wstrb_d = 4'b0000;
          tmo_d       = ~bus_ack;
          if (bus_ack && state_q == LOAD_WAIT) begin
            wr_en_d   = (rd_q != '0);
            wr_addr_d = rd_q;
            wr_data_d = load_data;
          end
        end else begin
          pause_signal = 1'b1;
          cnt_d        = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    pause_signal = pause_signal & rst_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ld_mode_q   <= '0;
      ld_off_q    <= '0;
      rd_q        <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      mis_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ld_mode_q   <= ld_mode_d;
      ld_off_q    <= ld_off_d;
      rd_q        <= rd_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      mis_q       <= mis_d;
      tmo_q       <= tmo_d;
    end
  end

  assign bus_req         = bus_req_q;
  assign bus_we          = bus_we_q;
  assign bus_addr        = bus_addr_q;
  assign bus_wdata       = bus_wdata_q;
  assign bus_wstrb       = bus_wstrb_q;
  assign regs_write_en   = wr_en_q;
  assign regs_write_addr = wr_addr_q;
  assign regs_write_data = wr_data_q;
  assign misalign_error  = mis_q;
  assign bus_timeout     = tmo_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: driver pushes expected bus/writeback/error events,
// a monitor pops and compares them whenever the DUT presents one.
module tb_mem_access;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  mem_load_mode;
  logic [31:0] mem_load_addr;
  logic [4:0]  mem_load_regs_addr;
  logic [1:0]  mem_store_mode;
  logic [31:0] mem_store_addr;
  logic [31:0] mem_store_data;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        regs_write_en;
  logic [4:0]  regs_write_addr;
  logic [31:0] regs_write_data;
  logic        pause_signal, misalign_error, bus_timeout;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_load_mode(mem_load_mode), .mem_load_addr(mem_load_addr),
    .mem_load_regs_addr(mem_load_regs_addr),
    .mem_store_mode(mem_store_mode), .mem_store_addr(mem_store_addr),
    .mem_store_data(mem_store_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .regs_write_en(regs_write_en), .regs_write_addr(regs_write_addr),
    .regs_write_data(regs_write_data),
    .pause_signal(pause_signal), .misalign_error(misalign_error),
    .bus_timeout(bus_timeout)
  );

  typedef enum int {EV_BUS = 0, EV_WB = 1, EV_MIS = 2, EV_TO = 3} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [4:0]  rd;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Pop the oldest expected event and compare it to what the DUT shows now
  task automatic take_ev(input ev_kind_e kind);
    ev_t e;
    check("event_expected", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("event_kind", 32'(kind), 32'(e.kind));
    if (e.kind != kind) return;
    case (kind)
      EV_BUS: begin
        check("bus_we", 32'(bus_we), 32'(e.we));
        check("bus_addr", bus_addr, e.addr);
        check("bus_wstrb", 32'(bus_wstrb), 32'(e.strb));
        if (e.we) check("bus_wdata", bus_wdata, e.wdata);
      end
      EV_WB: begin
        check("wb_addr", 32'(regs_write_addr), 32'(e.rd));
        check("wb_data", regs_write_data, e.data);
      end
      default: ;
    endcase
  endtask

  initial begin : monitor
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (regs_write_en === 1'b1)  take_ev(EV_WB);
      if (bus_timeout === 1'b1)    take_ev(EV_TO);
      if (misalign_error === 1'b1) take_ev(EV_MIS);
      if (bus_req === 1'b1 && !prev_req) take_ev(EV_BUS);
      prev_req = (bus_req === 1'b1);
    end
  end

  task automatic idle_cycle();
    @(negedge clk);
    mem_load_mode  = 3'b111;
    mem_store_mode = 2'b00;
    bus_ack        = 1'b0;
  endtask

  // One upstream request plus the bus slave's response; the request is held while stalled
  task automatic do_txn(input logic [2:0] lm, input logic [31:0] la, input logic [4:0] rd,
                        input logic [1:0] sm, input logic [31:0] sa, input logic [31:0] sd,
                        input int waits, input logic [31:0] rdata, input bit no_ack);
    bit          lvalid, svalid, aligned, sgn;
    int          size, off;
    logic [31:0] addr;
    logic [7:0]  by [4];
    longint      val;
    ev_t         e;
    @(negedge clk);
    mem_load_mode      = lm;
    mem_load_addr      = la;
    mem_load_regs_addr = rd;
    mem_store_mode     = sm;
    mem_store_addr     = sa;
    mem_store_data     = sd;
    bus_ack            = 1'($urandom_range(0, 1));
    bus_rdata          = $urandom;
    lvalid = (lm inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    svalid = (sm != 2'b00);
    size   = 1;
    addr   = 32'd0;
    if (lvalid) begin
      size = 1 << lm[1:0];
      addr = la;
    end else if (svalid) begin
      size = 1 << (int'(sm) - 1);
      addr = sa;
    end
    off     = int'(addr[1:0]);
    aligned = (off % size) == 0;
    #1;
    check("pause_request", 32'(pause_signal), 32'((lvalid || svalid) && aligned));
    if (!(lvalid || svalid)) return;
    if (!aligned) begin
      e.kind = EV_MIS;
      exp_q.push_back(e);
      return;
    end
    e.kind  = EV_BUS;
    e.we    = !lvalid;
    e.addr  = addr & 32'hFFFF_FFFC;
    e.wdata = '0;
    e.strb  = '0;
    if (!lvalid) begin
      for (int b = 0; b < 4; b++) e.wdata[8*b +: 8] = sd[8*(b % size) +: 8];
      e.strb = 4'(((1 << size) - 1) << off);
    end
    exp_q.push_back(e);
    if (no_ack) begin
      e.kind = EV_TO;
      exp_q.push_back(e);
      for (int k = 0; k < int'(TO); k++) begin
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        check("req_until_timeout", 32'(bus_req), 32'd1);
        check("pause_until_timeout", 32'(pause_signal), 32'(k < int'(TO) - 1));
      end
      return;
    end
    for (int k = 0; k < waits; k++) begin
      @(negedge clk);
      bus_ack = 1'b0;
      #1;
      check("req_wait", 32'(bus_req), 32'd1);
      check("pause_wait", 32'(pause_signal), 32'd1);
    end
    @(negedge clk);
    bus_ack   = 1'b1;
    bus_rdata = rdata;
    #1;
    check("req_ack", 32'(bus_req), 32'd1);
    check("pause_ack", 32'(pause_signal), 32'd0);
    if (lvalid && rd != 5'd0) begin
      for (int i = 0; i < 4; i++) by[i] = rdata[8*i +: 8];
      val = 0;
      for (int i = 0; i < size; i++) val = val | (longint'(by[off + i]) << (8 * i));
      sgn = (lm[2] == 1'b0) && (size < 4);
      if (sgn && ((val >> (8 * size - 1)) & 1) == 1) val = val - (longint'(1) << (8 * size));
      e.kind = EV_WB;
      e.rd   = rd;
      e.data = 32'(val);
      exp_q.push_back(e);
    end
  endtask

  initial begin : driver
    rst_n              = 1'b0;
    mem_load_mode      = 3'b010;
    mem_load_addr      = 32'h0000_0100;
    mem_load_regs_addr = 5'd3;
    mem_store_mode     = 2'b00;
    mem_store_addr     = '0;
    mem_store_data     = '0;
    bus_ack            = 1'b0;
    bus_rdata          = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs_zero", 32'(|{bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
          regs_write_en, regs_write_addr, regs_write_data, misalign_error, bus_timeout}), 32'd0);
    check("reset_pause_low", 32'(pause_signal), 32'd0);
    mem_load_mode = 3'b111;
    rst_n = 1'b1;

    do_txn(3'b000, 32'h0000_1003, 5'd5, 2'b00, 32'd0, 32'd0, 0, 32'h80AA_BBCC, 1'b0);
    do_txn(3'b111, 32'd0, 5'd0, 2'b10, 32'h0000_2002, 32'h1234_ABCD, 2, 32'd0, 1'b0);
    do_txn(3'b010, 32'h0000_0006, 5'd4, 2'b00, 32'd0, 32'd0, 0, 32'd0, 1'b0);
    do_txn(3'b101, 32'h0000_0010, 5'd6, 2'b00, 32'd0, 32'd0, 0, 32'd0, 1'b1);
    do_txn(3'b010, 32'h0000_0020, 5'd0, 2'b00, 32'd0, 32'd0, 3, 32'hDEAD_BEEF, 1'b0);
    do_txn(3'b001, 32'h0000_0032, 5'd12, 2'b11, 32'h0000_0044, 32'h5555_AAAA, 0, 32'h8001_7FFF, 1'b0);
    do_txn(3'b011, 32'h0000_0001, 5'd9, 2'b01, 32'h0000_0051, 32'h0000_00E7, 1, 32'd0, 1'b0);

    // Reset while a load is waiting, then a stray ack after reset
    do_txn(3'b010, 32'h0000_0040, 5'd9, 2'b00, 32'd0, 32'd0, 0, 32'd0, 1'b1);
    idle_cycle();
    @(negedge clk);
    mem_load_mode      = 3'b010;
    mem_load_addr      = 32'h0000_0080;
    mem_load_regs_addr = 5'd11;
    begin
      ev_t e;
      e.kind = EV_BUS; e.we = 1'b0; e.addr = 32'h0000_0080; e.wdata = '0; e.strb = '0;
      e.rd = '0; e.data = '0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    #1;
    check("rst_test_req", 32'(bus_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("pause_in_reset", 32'(pause_signal), 32'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    mem_load_mode = 3'b111;
    bus_ack       = 1'b1;
    bus_rdata     = 32'h1234_5678;
    #1;
    check("post_reset_outputs_zero", 32'(|{bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
          regs_write_en, regs_write_addr, regs_write_data, misalign_error, bus_timeout}), 32'd0);
    check("post_reset_pause", 32'(pause_signal), 32'd0);
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("post_reset_no_wb", 32'(regs_write_en), 32'd0);
    check("post_reset_no_req", 32'(bus_req), 32'd0);

    for (int i = 0; i < 300; i++) begin
      do_txn(3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)),
             2'($urandom_range(0, 3)), $urandom, $urandom,
             $urandom_range(0, 3), $urandom, ($urandom_range(0, 9) == 0));
    end

    repeat (4) idle_cycle();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
